// File: rtl/ysyx_22051013_pipe_ctrl_if.sv
// Hazard request / pipeline control bundle for the central pipe controller.
// master: the stages (drive requests, receive controls); slave: the controller.
interface ysyx_22051013_pipe_ctrl_if #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
);
  logic            id_load_use;
  logic            id_jump_req;
  logic [PC_W-1:0] id_jump_pc;
  logic            ex_busy;
  logic            ex_trap_req;
  logic [PC_W-1:0] ex_trap_pc;
  logic            ls_busy;
  logic            if_busy;

  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_stall;
  logic             ex_ls_stall;
  logic             ls_wb_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_ls_flush;
  logic             ls_wb_flush;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_load_use, id_jump_req, id_jump_pc,
    output ex_busy, ex_trap_req, ex_trap_pc,
    output ls_busy, if_busy,
    input  pc_stall, if_id_stall, id_ex_stall,
    input  ex_ls_stall, ls_wb_stall,
    input  if_id_flush, id_ex_flush,
    input  ex_ls_flush, ls_wb_flush,
    input  redirect_valid, redirect_pc, stall_cnt
  );

  modport slave (
    input  id_load_use, id_jump_req, id_jump_pc,
    input  ex_busy, ex_trap_req, ex_trap_pc,
    input  ls_busy, if_busy,
    output pc_stall, if_id_stall, id_ex_stall,
    output ex_ls_stall, ls_wb_stall,
    output if_id_flush, id_ex_flush,
    output ex_ls_flush, ls_wb_flush,
    output redirect_valid, redirect_pc, stall_cnt
  );
endinterface

// File: rtl/ysyx_22051013_pipe_ctrl.sv
// Central 5-stage pipeline controller: freeze levels, trap/jump redirect, pending redirect.
// Ports: clk, rst (sync, active-high), io (slave: hazard requests in, stall/flush/redirect out).
module ysyx_22051013_pipe_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_22051013_pipe_ctrl_if.slave io
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [PC_W-1:0]  r_pend_pc;
  logic [PC_W-1:0]  w_pend_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic            w_trap_ok;
  logic            w_jump_ok;
  logic            w_req;
  logic [PC_W-1:0] w_tgt;

  logic w_fz_pc;
  logic w_fz_ifid;
  logic w_fz_idex;
  logic w_fz_exls;
  logic w_fz_idex_fl;
  logic w_fz_exls_fl;
  logic w_fz_lswb_fl;

  logic            w_pc_stall;
  logic            w_ifid_stall;
  logic            w_idex_stall;
  logic            w_exls_stall;
  logic            w_lswb_stall;
  logic            w_ifid_flush;
  logic            w_idex_flush;
  logic            w_exls_flush;
  logic            w_lswb_flush;
  logic            w_rv;
  logic [PC_W-1:0] w_rpc;

  // A trap only waits on LS; ex_busy/load_use belong to
  // younger work that the trap throws away anyway.
  assign w_trap_ok = io.ex_trap_req & ~io.ls_busy;

  // Jumps in WAIT_FETCH come from the wrong path.
  assign w_jump_ok = io.id_jump_req & ~io.ex_trap_req
                   & ~io.ls_busy & ~io.ex_busy
                   & ~io.id_load_use
                   & (r_state == S_RUN);

  assign w_req = w_trap_ok | w_jump_ok;
  assign w_tgt = w_trap_ok ? io.ex_trap_pc
                           : io.id_jump_pc;

  // Freeze levels, highest priority first.
  always_comb begin
    w_fz_pc      = 1'b0;
    w_fz_ifid    = 1'b0;
    w_fz_idex    = 1'b0;
    w_fz_exls    = 1'b0;
    w_fz_idex_fl = 1'b0;
    w_fz_exls_fl = 1'b0;
    w_fz_lswb_fl = 1'b0;
    if (io.ls_busy) begin
      w_fz_pc      = 1'b1;
      w_fz_ifid    = 1'b1;
      w_fz_idex    = 1'b1;
      w_fz_exls    = 1'b1;
      w_fz_lswb_fl = 1'b1;
    end else if (w_trap_ok) begin
      w_fz_pc      = 1'b0;
    end else if (io.ex_busy) begin
      w_fz_pc      = 1'b1;
      w_fz_ifid    = 1'b1;
      w_fz_idex    = 1'b1;
      w_fz_exls_fl = 1'b1;
    end else if (io.id_load_use) begin
      w_fz_pc      = 1'b1;
      w_fz_ifid    = 1'b1;
      w_fz_idex_fl = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_pend_pc   <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_pend_pc   <= w_pend_nxt;
      r_stall_cnt <= r_stall_cnt
                   + {{(CNT_W-1){1'b0}}, w_pc_stall};
    end
  end

  always_comb begin
    w_next     = r_state;
    w_pend_nxt = r_pend_pc;
    unique case (r_state)
      S_RUN: begin
        if (w_req && io.if_busy) begin
          w_next     = S_WAIT;
          w_pend_nxt = w_tgt;
        end
      end
      S_WAIT: begin
        if (!io.if_busy) begin
          w_next = S_RUN;
        end else if (w_trap_ok) begin
          w_pend_nxt = io.ex_trap_pc;
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    w_pc_stall   = 1'b0;
    w_ifid_stall = 1'b0;
    w_idex_stall = 1'b0;
    w_exls_stall = 1'b0;
    w_lswb_stall = 1'b0;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_exls_flush = 1'b0;
    w_lswb_flush = 1'b0;
    w_rv         = 1'b0;
    w_rpc        = '0;
    if (!rst) begin
      unique case (r_state)
        S_RUN: begin
          w_rv  = w_req & ~io.if_busy;
          w_rpc = w_rv ? w_tgt : '0;
        end
        S_WAIT: begin
          // A trap arriving as the fetch lands
          // supersedes the parked target.
          w_rv  = ~io.if_busy;
          if (w_rv)
            w_rpc = w_trap_ok ? io.ex_trap_pc
                              : r_pend_pc;
        end
        default: w_rv = 1'b0;
      endcase
      // Stale fetch must never reach decode while waiting.
      w_ifid_flush = w_trap_ok | w_jump_ok
                   | (r_state == S_WAIT);
      w_idex_flush = w_trap_ok | w_fz_idex_fl;
      w_exls_flush = w_fz_exls_fl;
      w_lswb_flush = w_fz_lswb_fl;
      // Flush wins over stall on the same register.
      w_ifid_stall = w_fz_ifid & ~w_ifid_flush;
      w_idex_stall = w_fz_idex & ~w_idex_flush;
      w_exls_stall = w_fz_exls & ~w_exls_flush;
      w_lswb_stall = 1'b0;
      // The redirect load itself overrides any PC hold.
      w_pc_stall   = ~w_rv & (w_fz_pc | io.if_busy
                   | (r_state == S_WAIT));
    end
  end

  assign io.pc_stall       = w_pc_stall;
  assign io.if_id_stall    = w_ifid_stall;
  assign io.id_ex_stall    = w_idex_stall;
  assign io.ex_ls_stall    = w_exls_stall;
  assign io.ls_wb_stall    = w_lswb_stall;
  assign io.if_id_flush    = w_ifid_flush;
  assign io.id_ex_flush    = w_idex_flush;
  assign io.ex_ls_flush    = w_exls_flush;
  assign io.ls_wb_flush    = w_lswb_flush;
  assign io.redirect_valid = w_rv;
  assign io.redirect_pc    = w_rpc;
  assign io.stall_cnt      = r_stall_cnt;

endmodule
